// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: eight single-cycle ops plus iterative unsigned MUL/DIVU/REMU.
// Operands are taken on a start/busy/done handshake; result and flags hold until next done.
module seq_alu #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  C,
  output logic                  L,
  output logic                  F,
  output logic                  Z,
  output logic                  N
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNot  = 4'd5;
  localparam logic [3:0] OpLsh  = 4'd6;
  localparam logic [3:0] OpAsh  = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;
  localparam logic [3:0] OpDivu = 4'd9;
  localparam logic [3:0] OpRemu = 4'd10;

  localparam logic [SW:0] CntInit = DATA_WIDTH[SW:0];
  localparam logic [SW:0] CntOne  = {{SW{1'b0}}, 1'b1};

  typedef enum logic {StIdle, StRun} state_e;

  state_e        r_state, w_state_nxt;
  logic [SW:0]   r_cnt;
  logic [3:0]    r_op;
  logic [W-1:0]  r_acc, r_lo, r_opnd;
  logic [W-1:0]  r_result;
  logic          r_done, r_c, r_l, r_f, r_z, r_n;

  logic          w_accept, w_iter_op, w_last;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [W:0]    w_sum, w_diff;
  logic [SW-1:0] w_amt;
  logic [W-1:0]  w_shl, w_shr, w_sar;
  logic [W-1:0]  w_alu_res;
  logic          w_alu_c, w_alu_l, w_alu_f, w_alu_n;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  // Low bits of |b| only depend on the low bits of b in two's complement.
  assign w_amt  = b[W-1] ? (~b[SW-1:0] + 1'b1) : b[SW-1:0];
  assign w_shl  = a << w_amt;
  assign w_shr  = a >> w_amt;
  assign w_sar  = $signed(a) >>> w_amt;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_l   = 1'b0;
    w_alu_f   = 1'b0;
    w_alu_n   = 1'b0;
    case (op)
      OpAdd: begin
        w_alu_res = w_sum[W-1:0];
        w_alu_c   = w_sum[W];
        w_alu_f   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OpSub: begin
        w_alu_res = w_diff[W-1:0];
        w_alu_c   = w_diff[W];
        w_alu_l   = w_diff[W];
        w_alu_f   = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
        w_alu_n   = ((a[W-1] == b[W-1]) && w_diff[W-1]) || (a[W-1] && !b[W-1]);
      end
      OpAnd:   w_alu_res = a & b;
      OpOr:    w_alu_res = a | b;
      OpXor:   w_alu_res = a ^ b;
      OpNot:   w_alu_res = ~a;
      OpLsh:   w_alu_res = b[W-1] ? w_shr : w_shl;
      OpAsh:   w_alu_res = b[W-1] ? w_sar : w_shl;
      default: w_alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath: r_acc/r_lo form the product (MUL) or remainder/quotient (DIV)
  // ---------------------------------------------------------------------------
  logic [W:0]   w_madd, w_rsh;
  logic [W-1:0] w_rsub;
  logic         w_ge;
  logic [W-1:0] w_step_acc, w_step_lo;
  logic [W-1:0] w_fin_res;
  logic         w_fin_c, w_fin_f;

  assign w_madd = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_rsh  = {r_acc, r_lo[W-1]};
  assign w_ge   = w_rsh >= {1'b0, r_opnd};
  // When w_ge holds, the true difference fits in W bits.
  assign w_rsub = w_rsh[W-1:0] - r_opnd;

  always_comb begin
    if (r_op == OpMul) begin
      w_step_acc = w_madd[W:1];
      w_step_lo  = {w_madd[0], r_lo[W-1:1]};
    end else begin
      w_step_acc = w_ge ? w_rsub : w_rsh[W-1:0];
      w_step_lo  = {r_lo[W-2:0], w_ge};
    end
  end

  always_comb begin
    w_fin_res = (r_op == OpRemu) ? w_step_acc : w_step_lo;
    w_fin_c   = (r_op == OpMul) && (w_step_acc != '0);
    w_fin_f   = (r_op != OpMul) && (r_opnd == '0);
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign w_accept  = (r_state == StIdle) && start;
  assign w_iter_op = (op == OpMul) || (op == OpDivu) || (op == OpRemu);
  assign w_last    = (r_cnt == CntOne);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_accept && w_iter_op) w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StRun);
  end

  // ---------------------------------------------------------------------------
  // Operand, step and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_c      <= 1'b0;
      r_l      <= 1'b0;
      r_f      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_iter_op) begin
          r_op   <= op;
          r_cnt  <= CntInit;
          r_acc  <= '0;
          r_lo   <= (op == OpMul) ? b : a;
          r_opnd <= (op == OpMul) ? a : b;
        end else begin
          r_result <= w_alu_res;
          r_c      <= w_alu_c;
          r_l      <= w_alu_l;
          r_f      <= w_alu_f;
          r_z      <= (w_alu_res == '0);
          r_n      <= w_alu_n;
          r_done   <= 1'b1;
        end
      end else if (r_state == StRun) begin
        r_acc <= w_step_acc;
        r_lo  <= w_step_lo;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          r_result <= w_fin_res;
          r_c      <= w_fin_c;
          r_l      <= 1'b0;
          r_f      <= w_fin_f;
          r_z      <= (w_fin_res == '0);
          r_n      <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;
  assign C      = r_c;
  assign L      = r_l;
  assign F      = r_f;
  assign Z      = r_z;
  assign N      = r_n;

endmodule
